// File: rtl/player_sequencer_if.sv
// Interface between player_sequencer, the button processors and the note/sample generator.
// The master side drives the control pulses and samples. The slave side is the sequencer.
interface player_sequencer_if #(
    parameter int SONG_W   = 2,
    parameter int SAMPLE_W = 16,
    parameter int OUT_W    = 24,
    parameter int VOL_W    = 3
);
    logic                       play_pause;
    logic                       next;
    logic                       prev;
    logic                       mode;
    logic                       vol_up;
    logic                       vol_down;
    logic                       song_done;
    logic                       new_frame;
    logic signed [SAMPLE_W-1:0] sample_in;

    logic [SONG_W-1:0]          song;
    logic                       play;
    logic                       restart;
    logic [1:0]                 repeat_mode;
    logic [VOL_W-1:0]           volume;
    logic signed [OUT_W-1:0]    left_data;
    logic signed [OUT_W-1:0]    right_data;
    logic                       frame_valid;

    modport master (
        output play_pause, next, prev, mode, vol_up, vol_down, song_done, new_frame, sample_in,
        input  song, play, restart, repeat_mode, volume, left_data, right_data, frame_valid
    );

    modport slave (
        input  play_pause, next, prev, mode, vol_up, vol_down, song_done, new_frame, sample_in,
        output song, play, restart, repeat_mode, volume, left_data, right_data, frame_valid
    );
endinterface

// File: rtl/player_sequencer.sv
// Playback controller: song selection, play/pause, repeat modes and auto-advance,
// plus a per-frame, volume-scaled stereo sample register for the codec.
module player_sequencer #(
    parameter int NUM_SONGS = 4,
    parameter int SONG_W    = 2,
    parameter int SAMPLE_W  = 16,
    parameter int OUT_W     = 24,
    parameter int VOL_W     = 3
) (
    input  logic                clk,
    input  logic                reset,
    player_sequencer_if.slave   bus
);
    localparam logic [1:0] ST_STOPPED = 2'd0;
    localparam logic [1:0] ST_PLAYING = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;

    localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
    localparam logic [VOL_W-1:0]  VOL_MAX   = '1;

    logic [1:0]              state;
    logic [1:0]              state_n;
    logic [SONG_W-1:0]       song_n;
    logic [SONG_W-1:0]       song_inc;
    logic [SONG_W-1:0]       song_dec;
    logic                    restart_n;
    logic [VOL_W-1:0]        volume_n;
    logic [VOL_W-1:0]        shift_amt;
    logic signed [OUT_W-1:0] widened;
    logic signed [OUT_W-1:0] scaled;

    assign song_inc = (bus.song == LAST_SONG) ? '0 : bus.song + 1'b1;
    assign song_dec = (bus.song == '0) ? LAST_SONG : bus.song - 1'b1;

    // Only the highest-priority transport pulse acts: play_pause > next > prev > song_done.
    always_comb begin
        state_n   = state;
        song_n    = bus.song;
        restart_n = 1'b0;
        if (bus.play_pause) begin
            case (state)
                ST_STOPPED: begin
                    state_n   = ST_PLAYING;
                    restart_n = 1'b1;
                end
                ST_PLAYING: state_n = ST_PAUSED;
                ST_PAUSED:  state_n = ST_PLAYING;
                default:    state_n = ST_STOPPED;
            endcase
        end else if (bus.next) begin
            song_n    = song_inc;
            restart_n = 1'b1;
        end else if (bus.prev) begin
            song_n    = song_dec;
            restart_n = 1'b1;
        end else if (bus.song_done && state == ST_PLAYING) begin
            case (bus.repeat_mode)
                2'd0: begin
                    if (bus.song == LAST_SONG) begin
                        state_n = ST_STOPPED;
                        song_n  = '0;
                    end else begin
                        song_n    = song_inc;
                        restart_n = 1'b1;
                    end
                end
                2'd1: begin
                    song_n    = song_inc;
                    restart_n = 1'b1;
                end
                2'd2:    restart_n = 1'b1;
                default: state_n   = ST_STOPPED;
            endcase
        end
    end

    always_comb begin
        volume_n = bus.volume;
        if (bus.vol_up && !bus.vol_down && bus.volume != VOL_MAX) begin
            volume_n = bus.volume + 1'b1;
        end else if (bus.vol_down && !bus.vol_up && bus.volume != '0) begin
            volume_n = bus.volume - 1'b1;
        end
    end

    // Left-justify the sample in the codec word, then each volume step below max is one arithmetic halving.
    always_comb begin
        shift_amt = VOL_MAX - bus.volume;
        widened   = OUT_W'(bus.sample_in) << (OUT_W - SAMPLE_W);
        scaled    = widened >>> shift_amt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_STOPPED;
            bus.song        <= '0;
            bus.play        <= 1'b0;
            bus.restart     <= 1'b0;
            bus.repeat_mode <= 2'd0;
            bus.volume      <= VOL_MAX;
        end else begin
            state           <= state_n;
            bus.song        <= song_n;
            bus.play        <= (state_n == ST_PLAYING);
            bus.restart     <= restart_n;
            bus.repeat_mode <= bus.mode ? bus.repeat_mode + 2'd1 : bus.repeat_mode;
            bus.volume      <= volume_n;
        end
    end

    // The registered play/volume are used here, so a pause coinciding with new_frame still emits audio.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.left_data   <= '0;
            bus.right_data  <= '0;
            bus.frame_valid <= 1'b0;
        end else if (bus.new_frame) begin
            bus.frame_valid <= 1'b1;
            if (!bus.play || bus.volume == '0) begin
                bus.left_data  <= '0;
                bus.right_data <= '0;
            end else begin
                bus.left_data  <= scaled;
                bus.right_data <= scaled;
            end
        end else begin
            bus.frame_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_player_sequencer.sv
// Self-checking bench for player_sequencer: directed test-plan steps followed by random pulses,
// all checked every cycle against a behavioural model of the playback rules.
module tb_player_sequencer;
    localparam int NUM_SONGS = 4;
    localparam int SONG_W    = 2;
    localparam int SAMPLE_W  = 16;
    localparam int OUT_W     = 24;
    localparam int VOL_W     = 3;
    localparam int VOL_MAX   = 7;

    logic clk = 1'b0;
    logic reset;

    int n_compared  = 0;
    int n_mismatched = 0;

    string m_state;
    int    m_song;
    int    m_rep;
    int    m_vol;
    int    m_word;
    bit    m_restart;
    bit    m_fv;

    player_sequencer_if #(.SONG_W(SONG_W), .SAMPLE_W(SAMPLE_W), .OUT_W(OUT_W), .VOL_W(VOL_W)) bus ();

    player_sequencer #(
        .NUM_SONGS(NUM_SONGS), .SONG_W(SONG_W), .SAMPLE_W(SAMPLE_W), .OUT_W(OUT_W), .VOL_W(VOL_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic int floor_div(input int a, input int d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_all();
        check_output("song",        32'(bus.song),        32'(m_song));
        check_output("play",        32'(bus.play),        32'(m_state == "PLAYING"));
        check_output("restart",     32'(bus.restart),     32'(m_restart));
        check_output("repeat_mode", 32'(bus.repeat_mode), 32'(m_rep));
        check_output("volume",      32'(bus.volume),      32'(m_vol));
        check_output("left_data",   {8'b0, bus.left_data},  {8'b0, 24'(m_word)});
        check_output("right_data",  {8'b0, bus.right_data}, {8'b0, 24'(m_word)});
        check_output("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
    endtask

    task automatic model_reset();
        m_state   = "STOPPED";
        m_song    = 0;
        m_rep     = 0;
        m_vol     = VOL_MAX;
        m_word    = 0;
        m_restart = 1'b0;
        m_fv      = 1'b0;
    endtask

    task automatic model_step(input bit pp, nx, pv, sd, md, vu, vd, nf, input logic [15:0] smp);
        bit was_playing = (m_state == "PLAYING");
        int old_vol     = m_vol;
        m_restart = 1'b0;
        if (pp) begin
            if (m_state == "STOPPED") begin
                m_state   = "PLAYING";
                m_restart = 1'b1;
            end else if (m_state == "PLAYING") m_state = "PAUSED";
            else m_state = "PLAYING";
        end else if (nx) begin
            m_song    = (m_song + 1) % NUM_SONGS;
            m_restart = 1'b1;
        end else if (pv) begin
            m_song    = (m_song + NUM_SONGS - 1) % NUM_SONGS;
            m_restart = 1'b1;
        end else if (sd && was_playing) begin
            case (m_rep)
                0: if (m_song == NUM_SONGS - 1) begin
                       m_state = "STOPPED";
                       m_song  = 0;
                   end else begin
                       m_song    = m_song + 1;
                       m_restart = 1'b1;
                   end
                1: begin m_song = (m_song + 1) % NUM_SONGS; m_restart = 1'b1; end
                2: m_restart = 1'b1;
                default: m_state = "STOPPED";
            endcase
        end
        if (md) m_rep = (m_rep + 1) % 4;
        if (vu && !vd && m_vol < VOL_MAX) m_vol++;
        if (vd && !vu && m_vol > 0) m_vol--;
        m_fv = nf;
        if (nf) begin
            if (was_playing && old_vol != 0)
                m_word = floor_div(int'($signed(smp)) * (1 << (OUT_W - SAMPLE_W)), 1 << (VOL_MAX - old_vol));
            else
                m_word = 0;
        end
    endtask

    task automatic drive(input bit pp, nx, pv, sd, md, vu, vd, nf, input logic [15:0] smp);
        bus.play_pause = pp;
        bus.next       = nx;
        bus.prev       = pv;
        bus.song_done  = sd;
        bus.mode       = md;
        bus.vol_up     = vu;
        bus.vol_down   = vd;
        bus.new_frame  = nf;
        bus.sample_in  = smp;
    endtask

    // One clock with the given pulses, model advanced in step, all outputs checked after the edge.
    task automatic apply_stimulus(input bit pp, nx, pv, sd, md, vu, vd, nf, input logic [15:0] smp);
        drive(pp, nx, pv, sd, md, vu, vd, nf, smp);
        model_step(pp, nx, pv, sd, md, vu, vd, nf, smp);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        check_all();
    endtask

    task automatic do_reset(input bit with_pulses);
        reset = 1'b1;
        if (with_pulses)
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'b1, 16'($urandom));
        else
            drive(0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        model_reset();
        check_all();
    endtask

    task automatic idle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        model_reset();
        @(posedge clk);
        #1;
        do_reset(1'b0);

        // play / pause / resume
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        check_output("first_play_restart", 32'(bus.restart), 32'd1);
        idle();
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        check_output("resume_no_restart", 32'(bus.restart), 32'd0);

        // wrap in both directions
        repeat (3) apply_stimulus(0, 1, 0, 0, 0, 0, 0, 0, 16'h0);
        apply_stimulus(0, 1, 0, 0, 0, 0, 0, 0, 16'h0);
        check_output("next_wrap", 32'(bus.song), 32'd0);
        apply_stimulus(0, 0, 1, 0, 0, 0, 0, 0, 16'h0);
        check_output("prev_wrap", 32'(bus.song), 32'd3);

        // auto-advance in each repeat mode from the last song
        apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0, 16'h0);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        apply_stimulus(0, 0, 1, 0, 1, 0, 0, 0, 16'h0);
        apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0, 16'h0);
        apply_stimulus(0, 0, 1, 0, 1, 0, 0, 0, 16'h0);
        apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0, 16'h0);
        check_output("repeat_one_song", 32'(bus.song), 32'd3);
        apply_stimulus(0, 0, 0, 0, 1, 0, 0, 0, 16'h0);
        apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0, 16'h0);
        check_output("stop_after_current", 32'(bus.play), 32'd0);

        // priority and song_done while paused
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        apply_stimulus(1, 1, 0, 1, 0, 0, 0, 0, 16'h0);
        apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0, 16'h0);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 16'h0);

        // volume scaling and saturation
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 16'h8000);
        check_output("full_scale_neg", {8'b0, bus.left_data}, 32'h0080_0000);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, 16'h0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, 16'h0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 16'h8000);
        check_output("vol5_neg", {8'b0, bus.left_data}, 32'h00E0_0000);
        apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0, 16'h0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 16'h4000);
        check_output("vol6_pos", {8'b0, bus.left_data}, 32'h0020_0000);
        repeat (6) apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, 16'h0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 1, 16'h7FFF);
        apply_stimulus(0, 0, 0, 0, 0, 1, 1, 1, 16'h1234);
        repeat (15) apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0, 16'h0);
        check_output("vol_saturate", 32'(bus.volume), 32'd7);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 16'h1357);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 1, 16'hC001);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 16'h2468);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 16'h0);

        // reach song 2, repeat all, volume 3 while playing, then reset with pulses
        repeat (3) apply_stimulus(0, 1, 0, 0, 0, 0, 0, 0, 16'h0);
        repeat (2) apply_stimulus(0, 0, 0, 0, 1, 0, 0, 0, 16'h0);
        repeat (4) apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, 16'h0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 16'h5A5A);
        do_reset(1'b1);
        check_output("reset_no_frame_valid", 32'(bus.frame_valid), 32'd0);

        // random pulses
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset(1'b1);
            end else begin
                apply_stimulus($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                               $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                               $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
                               $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                               16'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/player_sequencer.md
# player_sequencer

Parametrised playback controller between the button processors and the note/sample generator. It owns song selection across `NUM_SONGS` tracks with next/prev, play/pause, auto-advance and four repeat modes. It also owns a registered, volume-scaled stereo sample path, latched once per codec frame, that drives the audio interface's left and right play-data words.

## Interface
- `NUM_SONGS`, 4: number of songs; requires 1 ≤ `NUM_SONGS` ≤ 2^`SONG_W`.
- `SONG_W`, 2: width of the song index.
- `SAMPLE_W`, 16: signed input sample width.
- `OUT_W`, 24: codec word width; requires `OUT_W` ≥ `SAMPLE_W`.
- `VOL_W`, 3: volume width; `VOL_MAX` = 2^`VOL_W`-1.
- `clk` in 1: system clock, single clock domain.
- `reset` in 1: synchronous, active-high.
- `play_pause` in 1: one-cycle pulse from the button processor.
- `next`, `prev` in 1: one-cycle pulses.
- `mode` in 1: one-cycle pulse; advances `repeat_mode`.
- `vol_up`, `vol_down` in 1: one-cycle pulses.
- `song_done` in 1: one-cycle pulse from the generator at end of the current song.
- `new_frame` in 1: one-cycle pulse per codec frame.
- `sample_in` in `SAMPLE_W`: signed sample from the generator.
- `song` out `SONG_W`: current song index.
- `play` out 1: high in PLAYING.
- `restart` out 1: one-cycle pulse; the generator reloads the song at `song`.
- `repeat_mode` out 2: 0 = off, 1 = all, 2 = one, 3 = stop-after-current.
- `volume` out `VOL_W`: current volume.
- `left_data`, `right_data` out `OUT_W`: signed codec words.
- `frame_valid` out 1: one-cycle pulse when the data words update.

## Operation
- States: STOPPED, PLAYING, PAUSED.
- Reset values:
  - State STOPPED.
  - `song`=0, `play`=0, `restart`=0, `repeat_mode`=0.
  - `volume`=`VOL_MAX`.
  - Data words 0, `frame_valid`=0.
- Control priority when pulses coincide in one cycle: `play_pause` > `next` > `prev` > `song_done`. Only the winner acts. `mode` and the volume pulses are independent of this priority.
- `play_pause`:
  - STOPPED → PLAYING, with `restart`.
  - PLAYING → PAUSED.
  - PAUSED → PLAYING, no `restart` (resume).
- `next`:
  - `song` ← `song`+1, wrapping `NUM_SONGS`-1 → 0.
  - Pulses `restart`; state is unchanged.
- `prev`:
  - `song` ← `song`-1, wrapping 0 → `NUM_SONGS`-1.
  - Pulses `restart`; state is unchanged.
- `song_done` is honoured only in PLAYING; it is ignored in PAUSED and STOPPED. Action by `repeat_mode`:
  - 0: if `song`=`NUM_SONGS`-1, go to STOPPED with `song`←0 and no `restart`; otherwise `song`+1 with `restart`.
  - 1: `song`+1 with wrap, plus `restart`.
  - 2: same `song`, plus `restart`.
  - 3: go to STOPPED, `song` unchanged, no `restart`.
- `mode`: `repeat_mode` ← `repeat_mode`+1, wrapping 3 → 0.
- Volume:
  - `vol_up` saturates at `VOL_MAX`; `vol_down` saturates at 0.
  - If both pulse in the same cycle, no change.
- Sample path, on `new_frame`:
  - If `play`=0 or `volume`=0: both words ← 0.
  - Otherwise: both words ← ({`sample_in`, (`OUT_W`-`SAMPLE_W`) zeros}) >>> (`VOL_MAX`-`volume`). The shift is arithmetic (sign-preserving), so each step is −6 dB.
  - `left_data` always equals `right_data`.
  - Words hold their value between frames.
- `NUM_SONGS`=1: `next` and `prev` keep `song`=0 but still pulse `restart`.

## Timing
- All outputs are registered and change on the clock edge after the triggering input cycle (1-cycle latency).
- `restart` is high for exactly one cycle and is coincident with the new `song` value.
- `frame_valid` is high the cycle after `new_frame` and is coincident with the updated words.
- Back-to-back `new_frame` pulses are each honoured.
- `play` samples at the `new_frame` cycle: a pause in the same cycle as `new_frame` still uses the pre-edge `play`=1.
- Reset mid-operation: on the next edge, all registers return to reset values; pulses present in the reset cycle are discarded.
- Inputs are not synchronised here; they arrive in `clk` domain from the button processors.

## Test plan
- Reset then `play_pause`:
  - `play`=1, `song`=0, and `restart` high for one cycle.
  - A second `play_pause` gives `play`=0.
  - A third gives `play`=1 with no `restart`.
- Wrap, with `NUM_SONGS`=4:
  - From `song`=3, `next` → 0.
  - From `song`=0, `prev` → 3.
  - Each step pulses `restart` once.
- Auto-advance, PLAYING at `song`=3:
  - `repeat_mode`=0 + `song_done` → STOPPED, `song`=0.
  - `repeat_mode`=1 → `song`=0, still playing.
  - `repeat_mode`=2 → `song`=3 with `restart`.
  - `repeat_mode`=3 → STOPPED, `song`=3.
- Priority:
  - `play_pause`, `next` and `song_done` in the same PLAYING cycle → PAUSED, `song` unchanged, no `restart`.
  - `song_done` while PAUSED → no effect.
- Volume/sample, `SAMPLE_W`=16, `OUT_W`=24:
  - `sample_in`=16'h8000, `volume`=7 → words 24'h800000.
  - `volume`=5 → 24'hE00000.
  - `sample_in`=16'h4000, `volume`=6 → 24'h200000.
  - `volume`=0 → 0.
  - Eight `vol_up` pulses from 7 → stays 7.
- Reset mid-play:
  - Assert `reset` with `song`=2, `repeat_mode`=1, `volume`=3, PLAYING.
  - Next edge: all outputs at reset values; a `new_frame` in the reset cycle gives no `frame_valid`.
